// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle controller.
//   - state_e     : 4-bit FSM state codes (also exported on state_dbg)
//   - ALU_*       : ALUControl codes
//   - IMM_*       : ImmSrc codes
//   - OP_*        : opcode constants recognised by the controller
//   - SRCA_/SRCB_/RES_ : datapath mux select codes
//   - imm_sel()   : opcode -> ImmSrc
//   - branch_taken(): funct3 + ALU flags -> branch decision
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_JALR    = 4'd11,
        S_JALRPC  = 4'd12,
        S_AUIPC   = 4'd13,
        S_HALT    = 4'd14
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // U-format covers both LUI and AUIPC encodings even though only AUIPC
    // executes; the immediate format is a property of the opcode alone.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] s;
        case (op)
            OP_STORE:          s = IMM_S;
            OP_BRANCH:         s = IMM_B;
            OP_JAL:            s = IMM_J;
            OP_AUIPC, OP_LUI:  s = IMM_U;
            default:           s = IMM_I;
        endcase
        return s;
    endfunction

    // Flags come from A - B in the BRANCH cycle; Carry=1 means no borrow,
    // so unsigned less-than is !Carry and signed less-than is N^V.
    function automatic logic branch_taken(input logic [2:0] func3,
                                          input logic z, input logic n,
                                          input logic c, input logic v);
        logic t;
        case (func3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = n ^ v;
            3'b101:  t = ~(n ^ v);
            3'b110:  t = ~c;
            3'b111:  t = c;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: funct3/funct7b5 -> ALUControl for the execute states.
//   func3     in  3  instruction funct3
//   func7b5   in  1  instr[30]; selects SUB only for R-type funct3=000
//   is_rtype  in  1  1 = register-register op, 0 = immediate op
//   ALUControl out 3 ALU operation code
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       func7b5,
    input  logic       is_rtype,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (func3)
            // ADDI has no SUB form: instr[30] there is immediate bits.
            3'b000:  ALUControl = (is_rtype && func7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ALUControl = ALU_SLL;
            3'b010:  ALUControl = ALU_SLT;
            3'b011:  ALUControl = ALU_ADD;
            3'b100:  ALUControl = ALU_XOR;
            3'b101:  ALUControl = ALU_SRL;
            3'b110:  ALUControl = ALU_OR;
            3'b111:  ALUControl = ALU_AND;
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RISC-V datapath.
//   clk, reset                 clock, synchronous active-low reset
//   op, func3, func7b5         decode fields from the instruction register
//   Zero/Negative/Carry/Overflow  ALU flags of the current cycle
//   RegWrite IRWrite PCWrite MemWrite AdrSrc   enables / address select
//   ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl  datapath selects
//   illegal_instr              halt flag, state_dbg current state code
// Build option: CTRL_ILLEGAL_HALT_EN -- unsupported opcodes park the FSM in
// HALT with illegal_instr=1 until reset; otherwise they retire as a NOP.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       Overflow,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic       rw_c, irw_c, pcw_c, mw_c;
    logic [2:0] dec_alu;
    logic       exec_c;

    alu_decoder u_alu_dec (
        .func3      (func3),
        .func7b5    (func7b5),
        .is_rtype   (state_q == S_EXECR),
        .ALUControl (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rw_c      = 1'b0;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        mw_c      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WD;
        exec_c    = 1'b0;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                irw_c     = 1'b1;
                pcw_c     = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target OldPC+imm while decoding.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef CTRL_ILLEGAL_HALT_EN
                    default:           state_d = S_HALT;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                state_d = op[5] ? S_MEMWR : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw_c      = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                mw_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_A;
                exec_c  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                exec_c  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut still holds the target computed in DECODE.
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                pcw_c      = branch_taken(func3, Zero, Negative, Carry, Overflow);
                state_d    = S_FETCH;
            end
            S_JAL, S_JALRPC: begin
                // PC <- ALUOut (target) while ALU forms the link OldPC+4.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pcw_c   = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALRPC;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (exec_c) ALUControl = dec_alu;
    end

    // Enables are gated by reset so an instruction caught mid-flight
    // performs no write in the reset cycle itself.
    assign RegWrite = rw_c  & reset;
    assign IRWrite  = irw_c & reset;
    assign PCWrite  = pcw_c & reset;
    assign MemWrite = mw_c  & reset;

    assign ImmSrc    = imm_sel(op);
    assign state_dbg = state_q;

`ifdef CTRL_ILLEGAL_HALT_EN
    assign illegal_instr = reset & (state_q == S_HALT);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7b5;
    logic       Zero, Negative, Carry, Overflow;
    logic       RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .func3(func3), .func7b5(func7b5),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal_instr(illegal_instr),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw, irw, pcw, mw, adr;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu;
        logic       ill;
    } ctl_t;

    ctl_t act;
    assign act = {RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};

    int n_chk  = 0;
    int n_fail = 0;
    int trace_q[$];

`ifdef CTRL_ILLEGAL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // ALU op by funct3 for the non-SUB case: ADD SLL SLT ADD XOR SRL OR AND
    logic [2:0] alu_tab [8] = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};

    // Reference model: per-instruction list of visited states.
    task automatic build_trace(input logic [6:0] o);
        trace_q.delete();
        trace_q.push_back(0);
        trace_q.push_back(1);
        case (o)
            7'b0000011: begin trace_q.push_back(2); trace_q.push_back(3); trace_q.push_back(4); end
            7'b0100011: begin trace_q.push_back(2); trace_q.push_back(5); end
            7'b0110011: begin trace_q.push_back(6); trace_q.push_back(8); end
            7'b0010011: begin trace_q.push_back(7); trace_q.push_back(8); end
            7'b1100011: trace_q.push_back(9);
            7'b1101111: begin trace_q.push_back(10); trace_q.push_back(8); end
            7'b1100111: begin trace_q.push_back(11); trace_q.push_back(12); trace_q.push_back(8); end
            7'b0010111: begin trace_q.push_back(13); trace_q.push_back(8); end
            default: if (HALT_EN) trace_q.push_back(14);
        endcase
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0010111, 7'b0110111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic taken_of();
        case (func3)
            3'd0: return Zero;
            3'd1: return !Zero;
            3'd4: return Negative != Overflow;
            3'd5: return Negative == Overflow;
            3'd6: return !Carry;
            3'd7: return Carry;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input int st);
        ctl_t e = '0;
        e.imm = imm_of(op);
        case (st)
            0:  begin e.irw = 1; e.pcw = 1; e.sb = 2; e.rs = 2; end
            1:  begin e.sa = 1; e.sb = 1; end
            2:  begin e.sa = 2; e.sb = 1; end
            3:  e.adr = 1;
            4:  begin e.rs = 1; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2; e.alu = (func3 == 0 && func7b5) ? 3'd1 : alu_tab[func3]; end
            7:  begin e.sa = 2; e.sb = 1; e.alu = alu_tab[func3]; end
            8:  e.rw = 1;
            9:  begin e.sa = 2; e.alu = 3'd1; e.pcw = taken_of(); end
            10, 12: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            11: begin e.sa = 2; e.sb = 1; end
            13: begin e.sa = 1; e.sb = 1; end
            14: e.ill = 1;
            default: ;
        endcase
        if (!reset) begin e.rw = 0; e.irw = 0; e.pcw = 0; e.mw = 0; e.ill = 0; end
        return e;
    endfunction

    // Precondition: called at posedge+1 with the FSM in FETCH.
    // zf < 0 randomises Zero each cycle, otherwise forces it.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int zf, input string tag);
        ctl_t e;
        op = o; func3 = f3; func7b5 = f7;
        build_trace(o);
        for (int i = 0; i < trace_q.size(); i++) begin
            {Zero, Negative, Carry, Overflow} = 4'($urandom);
            if (zf >= 0) Zero = zf[0];
            @(negedge clk);
            n_chk++;
            if (state_dbg !== 4'(trace_q[i])) begin
                n_fail++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, state_dbg, trace_q[i]);
            end
            e = exp_ctl(trace_q[i]);
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s ctl st%0d op=%b f3=%0d: got %h want %h", tag, trace_q[i], o, f3, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 7'b0000011; func3 = 0; func7b5 = 0;
        {Zero, Negative, Carry, Overflow} = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (state_dbg !== 4'd0 || {RegWrite, IRWrite, PCWrite, MemWrite, illegal_instr} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d en=%b want st=0 en=00000", state_dbg,
                     {RegWrite, IRWrite, PCWrite, MemWrite, illegal_instr});
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_rtype_sub();
        run_instr(7'b0110011, 3'b000, 1'b1, -1, "rtype_sub");
    endtask

    task automatic test_branch_bne();
        run_instr(7'b1100011, 3'b001, 1'b0, 0, "bne_taken");
        run_instr(7'b1100011, 3'b001, 1'b0, 1, "bne_not_taken");
    endtask

    task automatic test_store();
        run_instr(7'b0100011, 3'b010, 1'b0, -1, "store");
    endtask

    task automatic test_jalr();
        run_instr(7'b1100111, 3'b000, 1'b0, -1, "jalr");
    endtask

    task automatic test_illegal();
        run_instr(7'b0110111, 3'b000, 1'b0, -1, "illegal");
        if (HALT_EN) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                n_chk++;
                if (state_dbg !== 4'd14 || illegal_instr !== 1'b1 ||
                    {RegWrite, IRWrite, PCWrite, MemWrite} !== 4'b0) begin
                    n_fail++;
                    $display("FAIL halt_hold cyc%0d: got st=%0d ill=%b want st=14 ill=1", k, state_dbg, illegal_instr);
                end
                @(posedge clk); #1;
            end
            reset = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (state_dbg !== 4'd0 || illegal_instr !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_reset: got st=%0d ill=%b want st=0 ill=0", state_dbg, illegal_instr);
            end
            @(posedge clk); #1;
            reset = 1'b1;
        end
    endtask

    task automatic test_reset_midinstr();
        op = 7'b0000011; func3 = 3'b010; func7b5 = 0;
        repeat (3) @(posedge clk);   // FETCH, DECODE, MEMADR
        #1;
        reset = 1'b0;                // now in MEMREAD
        @(negedge clk);
        n_chk++;
        if (state_dbg !== 4'd3 || {RegWrite, IRWrite, PCWrite, MemWrite} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_memread: got st=%0d en=%b want st=3 en=0000", state_dbg,
                     {RegWrite, IRWrite, PCWrite, MemWrite});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (state_dbg !== 4'd0 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_memwb: got st=%0d rw=%b want st=0 rw=0", state_dbg, RegWrite);
        end
        @(posedge clk); #1;          // back in DECODE; let it retire as a full load
        build_trace(7'b0000011);
        repeat (trace_q.size() - 1) @(posedge clk);
        #1;
        run_instr(7'b0000011, 3'b010, 1'b0, -1, "lw_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
                                 7'b0110111, 7'b1111111};
        int nops;
        nops = HALT_EN ? 8 : 10;
        for (int k = 0; k < 40; k++) begin
            run_instr(ops[$urandom_range(nops - 1)], 3'($urandom), 1'($urandom), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_branch_bne();
        test_store();
        test_jalr();
        test_reset_midinstr();
        test_back_to_back();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
